// File: rtl/boa_hazard_sched.sv
// boa_hazard_sched: Boa32 IF/ID/EX hazard scheduler with a late-result scoreboard, redirect flush and stall hang detect.
// Optional BOA_STALL_PERF_EN adds stall_cycles/flush_cycles performance counters.
module boa_hazard_sched #(
  parameter int FLUSH_CYCLES  = 2,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_has_rs1,
  input  logic [4:0]  id_rs1,
  input  logic        id_has_rs2,
  input  logic [4:0]  id_rs2,
  input  logic        id_has_rd,
  input  logic [4:0]  id_rd,
  input  logic        id_long,
  input  logic        ex_busy,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        redirect,
  output logic        fw_stall_if,
  output logic        fw_stall_id,
  output logic        fw_stall_ex,
  output logic        flush_id,
  output logic [31:0] sb_busy,
`ifdef BOA_STALL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
`endif
  output logic        hang
);
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;
  localparam logic [3:0]  FL_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT = 16'(STALL_TIMEOUT);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic [31:0] sb_q, sb_d, sbc;
  logic        hang_q, hang_d, raw, issue;
  always_comb begin
    sbc         = wb_valid ? (sb_q & ~(32'd1 << wb_rd)) : sb_q;
    flush_id    = redirect || (state_q == FLUSH);
    raw         = id_valid && !flush_id &&
                  ((id_has_rs1 && sbc[id_rs1]) || (id_has_rs2 && sbc[id_rs2]));
    fw_stall_ex = !flush_id && ex_busy;
    fw_stall_id = !flush_id && (raw || ex_busy);
    fw_stall_if = fw_stall_id;
    issue       = id_valid && !fw_stall_id && !flush_id;
    // A new long writer wins over a same-cycle writeback to the same register.
    sb_d        = sbc | ((issue && id_has_rd && id_long && id_rd != 5'd0) ? (32'd1 << id_rd) : 32'd0);
    sb_d[0]     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    scnt_d      = scnt_q;
    case (state_q)
      RUN: begin
        state_d = redirect ? FLUSH : fw_stall_id ? HOLD : RUN;
        cnt_d   = redirect ? FL_LOAD : cnt_q;
        scnt_d  = (!redirect && fw_stall_id) ? 16'd1 : 16'd0;
      end
      HOLD: begin
        state_d = redirect ? FLUSH : fw_stall_id ? HOLD : RUN;
        cnt_d   = redirect ? FL_LOAD : cnt_q;
        scnt_d  = (redirect || !fw_stall_id) ? 16'd0 : (scnt_q == 16'hffff) ? scnt_q : scnt_q + 16'd1;
      end
      default: begin
        state_d = (!redirect && cnt_q == 4'd0) ? RUN : FLUSH;
        cnt_d   = redirect ? FL_LOAD : (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        scnt_d  = 16'd0;
      end
    endcase
    hang_d = hang_q || (state_d == HOLD && scnt_d >= TIMEOUT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      scnt_q  <= 16'd0;
      sb_q    <= 32'd0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      sb_q    <= sb_d;
      hang_q  <= hang_d;
    end
  end
  assign sb_busy = sb_q;
  assign hang    = hang_q;
`ifdef BOA_STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_cycles_q, flush_cycles_d;
  always_comb begin
    stall_cycles_d = fw_stall_id ? stall_cycles_q + 32'd1 : stall_cycles_q;
    flush_cycles_d = flush_id ? flush_cycles_q + 32'd1 : flush_cycles_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
      flush_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`else
`endif
endmodule

// File: tb/tb_boa_hazard_sched.sv
// tb_boa_hazard_sched: directed stimulus with queued expectations checked by a negedge monitor.
module tb_boa_hazard_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_has_rs1, id_has_rs2, id_has_rd, id_long;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_busy, wb_valid, redirect;
  logic        fw_stall_if, fw_stall_id, fw_stall_ex, flush_id, hang;
  logic [31:0] sb_busy;
`ifdef BOA_STALL_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct {
    string       nm;
    logic        sid;
    logic        sex;
    logic        fl;
    logic [31:0] sb;
    logic        hg;
  } exp_t;
  exp_t exp_q[$];

  boa_hazard_sched dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_has_rs1(id_has_rs1), .id_rs1(id_rs1),
    .id_has_rs2(id_has_rs2), .id_rs2(id_rs2), .id_has_rd(id_has_rd), .id_rd(id_rd),
    .id_long(id_long), .ex_busy(ex_busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .redirect(redirect), .fw_stall_if(fw_stall_if), .fw_stall_id(fw_stall_id),
    .fw_stall_ex(fw_stall_ex), .flush_id(flush_id), .sb_busy(sb_busy),
`ifdef BOA_STALL_PERF_EN
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
    .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, string what, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, what, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "stall_id", 32'(fw_stall_id), 32'(e.sid));
        chk(e.nm, "stall_if", 32'(fw_stall_if), 32'(e.sid));
        chk(e.nm, "stall_ex", 32'(fw_stall_ex), 32'(e.sex));
        chk(e.nm, "flush_id", 32'(flush_id), 32'(e.fl));
        chk(e.nm, "sb_busy", sb_busy, e.sb);
        chk(e.nm, "hang", 32'(hang), 32'(e.hg));
      end
    end
  end

  task automatic step(string nm, logic sid, logic sex, logic fl, logic [31:0] sb, logic hg);
    exp_t e;
    e.nm = nm; e.sid = sid; e.sex = sex; e.fl = fl; e.sb = sb; e.hg = hg;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_has_rs1 = 0; id_rs1 = 0; id_has_rs2 = 0; id_rs2 = 0;
    id_has_rd = 0; id_rd = 0; id_long = 0;
    ex_busy = 0; wb_valid = 0; wb_rd = 0; redirect = 0;
  endtask

  task automatic id(logic r1h, logic [4:0] r1, logic r2h, logic [4:0] r2, logic rdh, logic [4:0] rd, logic lg);
    id_valid = 1; id_has_rs1 = r1h; id_rs1 = r1; id_has_rs2 = r2h; id_rs2 = r2;
    id_has_rd = rdh; id_rd = rd; id_long = lg;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // load-use stall released by matching writeback
    id(0, 0, 0, 0, 1, 5, 1);          step("lw5", 0, 0, 0, 32'h0, 0);
    id(1, 5, 0, 0, 1, 6, 0);          step("add_stall1", 1, 0, 0, 32'h20, 0);
                                      step("add_stall2", 1, 0, 0, 32'h20, 0);
    wb_valid = 1; wb_rd = 5;          step("add_wbfwd", 0, 0, 0, 32'h20, 0);
    idle();                           step("sb_cleared", 0, 0, 0, 32'h0, 0);
    // async reset in HOLD
    id(0, 0, 0, 0, 1, 5, 1);          step("lw5b", 0, 0, 0, 32'h0, 0);
    id(1, 5, 0, 0, 1, 6, 0);          step("hold1", 1, 0, 0, 32'h20, 0);
                                      step("hold2", 1, 0, 0, 32'h20, 0);
    rst_n = 0;                        step("in_reset", 0, 0, 0, 32'h0, 0);
    rst_n = 1; idle();                step("post_reset", 0, 0, 0, 32'h0, 0);
    // same-cycle set and clear: set wins
    id(0, 0, 0, 0, 1, 7, 1); wb_valid = 1; wb_rd = 7;
                                      step("setclr", 0, 0, 0, 32'h0, 0);
    idle();                           step("set_wins", 0, 0, 0, 32'h80, 0);
    wb_valid = 1; wb_rd = 7;          step("wb7", 0, 0, 0, 32'h80, 0);
    idle();                           step("wb7_done", 0, 0, 0, 32'h0, 0);
    // redirect from HOLD, flushed long op must not set scoreboard
    id(0, 0, 0, 0, 1, 5, 1);          step("lw5c", 0, 0, 0, 32'h0, 0);
    id(1, 5, 0, 0, 1, 6, 0);          step("hold_r", 1, 0, 0, 32'h20, 0);
    id(1, 5, 0, 0, 1, 9, 1); redirect = 1;
                                      step("redirect", 0, 0, 1, 32'h20, 0);
    redirect = 0;                     step("flush1", 0, 0, 1, 32'h20, 0);
                                      step("flush2", 0, 0, 1, 32'h20, 0);
                                      step("flush_end", 1, 0, 0, 32'h20, 0);
    idle(); wb_valid = 1; wb_rd = 5;  step("wb5c", 0, 0, 0, 32'h20, 0);
    idle();                           step("no_x9", 0, 0, 0, 32'h0, 0);
    // x0 is never busy
    id(0, 0, 0, 0, 1, 0, 1);          step("long_x0", 0, 0, 0, 32'h0, 0);
    id(1, 0, 1, 0, 0, 0, 0);          step("read_x0", 0, 0, 0, 32'h0, 0);
    idle();                           step("x0_idle", 0, 0, 0, 32'h0, 0);
    // persistent ex_busy raises sticky hang after 255 stall cycles
    ex_busy = 1;
    for (int k = 1; k <= 300; k++) step($sformatf("busy%0d", k), 1, 1, 0, 32'h0, k >= 256);
    ex_busy = 0;                      step("busy_off1", 0, 0, 0, 32'h0, 1);
                                      step("busy_off2", 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
